pattern_run_monitor: RTL

- Parametrised successor to the fixed 3-bit "111" monitor. Watches a WIDTH-bit input bus and raises ERR when a programmable PATTERN is held for THRESH consecutive enabled samples.
- Adds sticky/non-sticky alarm mode, software clear, sample enable, a saturating event counter and a run-length readout.
- Sits beside datapath buses as a protocol/stuck-value checker; all outputs are registered.

---
 rtl/pattern_run_monitor_pkg.sv | 15 +
 rtl/pattern_run_monitor_if.sv | 16 +
 rtl/pattern_run_monitor_sat_counter.sv | 22 ++
 rtl/pattern_run_monitor.sv | 81 ++++++++
 4 files changed

// File: rtl/pattern_run_monitor_pkg.sv
// Shared types and elaboration helpers for the pattern run monitor.
package prm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ALARM = 2'd2
  } state_t;

  // Width needed to hold a run length of 0..thresh.
  function automatic int rl_w(input int thresh);
    return $clog2(thresh + 1);
  endfunction

endpackage

// File: rtl/pattern_run_monitor_if.sv
// Monitored-bus bundle: sample inputs toward the monitor, alarm status back.
interface pattern_run_monitor_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8,
  parameter int RL_W  = 2
);
  logic             en;
  logic [WIDTH-1:0] Din;
  logic             clr;
  logic             ERR;
  logic [CNT_W-1:0] err_cnt;
  logic [RL_W-1:0]  run_len;

  modport master (output en, Din, clr, input ERR, err_cnt, run_len);
  modport slave  (input en, Din, clr, output ERR, err_cnt, run_len);
endinterface

// File: rtl/pattern_run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_run_monitor.sv
// Raises ERR when PATTERN is seen on Din for THRESH consecutive enabled samples;
// counts alarm events and exposes the current run length.
module pattern_run_monitor
  import prm_pkg::*;
#(
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] PATTERN = {WIDTH{1'b1}},
  parameter int               THRESH  = 3,
  parameter int               CNT_W   = 8,
  parameter bit               STICKY  = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  pattern_run_monitor_if.slave bus
);

  localparam int              RL_W = rl_w(THRESH);
  localparam logic [RL_W-1:0] LAST = RL_W'(THRESH - 1);

  if (THRESH < 1 || WIDTH < 1) begin : g_param_check
    $error("pattern_run_monitor: THRESH and WIDTH must both be >= 1");
  end

  state_t          state;
  logic [RL_W-1:0] run_q;
  logic            err_q;
  logic            match;
  logic            miss;
  logic            hit;

  assign match = bus.en && (bus.Din == PATTERN);
  assign miss  = bus.en && (bus.Din != PATTERN);
  // The next match completes the run; ALARM itself never re-fires.
  assign hit   = (state != ALARM) && (run_q == LAST);

  // err_q is set on an alarm event; only the non-sticky flavour drops it on a miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      run_q <= '0;
      err_q <= 1'b0;
    end else if (bus.clr) begin
      state <= IDLE;
      run_q <= '0;
      err_q <= 1'b0;
    end else if (match) begin
      case (state)
        IDLE, COUNT: begin
          run_q <= run_q + 1'b1;
          if (hit) begin
            state <= ALARM;
            err_q <= 1'b1;
          end else begin
            state <= COUNT;
          end
        end
        ALARM:   state <= ALARM;
        default: begin
          state <= IDLE;
          run_q <= '0;
        end
      endcase
    end else if (miss) begin
      state <= IDLE;
      run_q <= '0;
      if (!STICKY) err_q <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_evt_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr),
    .inc (match && hit),
    .q   (bus.err_cnt)
  );

  assign bus.ERR     = err_q;
  assign bus.run_len = run_q;

endmodule
